proc_ras: RTL and testbench
===========================

// Module: proc_ras
// PURPOSE
//  Parametrised return-address stack (RAS) that predicts jr targets for the
//  TinyRV1 processor family.
//  - jal-style calls push their return address; jr pops and predicts.
//  - Circular storage: overflow silently overwrites the oldest entry.
//  - Sits beside the fetch stage of the multicycle/pipelined ProcScycle
//    successors.
// PARAMETERS
//  DEPTH  8   number of entries; power of two, >= 2
//  AW     32  address width in bits
//  CW     $clog2(DEPTH+1)  count width (localparam, not overridable)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  flush      in   1      synchronous clear (mispredict recovery)
//  push_val   in   1      push push_addr this cycle
//  push_addr  in   AW     return address to push (stored unmodified)
//  pop_val    in   1      pop top entry this cycle
//  top_val    out  1      1 when stack holds >= 1 entry
//  top_addr   out  AW     predicted jr target = entry at top-of-stack
//  count      out  CW     valid entries, 0..DEPTH
//  overflow   out  1      sticky: a push occurred while count==DEPTH
//  underflow  out  1      one-cycle pulse: previous cycle popped while empty
// BEHAVIOUR
//  - Reset (async, immediate): tos=0, count=0, all entries=0, overflow=0,
//    underflow=0; hence top_val=0, top_addr=0.
//  - State: entry[DEPTH], tos pointer (log2 DEPTH bits, wraps mod DEPTH),
//    count.
//  - Outputs: top_val=(count!=0); top_addr=entry[tos] if count!=0, else 0.
//    Both are combinational from registered state; no input->output paths.
//  - Latency: a push or pop is visible on top_* and count the cycle after
//    the edge.
//  - Priority per edge: flush > push&pop > push > pop.
//  - flush: tos=0, count=0, overflow=0, underflow=0; push/pop that cycle are
//    ignored; entries keep their contents.
//  - push only: tos=tos+1 (mod DEPTH), entry[new tos]=push_addr,
//    count=min(count+1,DEPTH).
//    If count==DEPTH: oldest entry overwritten, count stays DEPTH,
//    overflow<=1.
//  - pop only, count>0: tos=tos-1 (mod DEPTH), count-1; entry contents
//    unchanged.
//  - pop only, count==0: no state change; underflow<=1 for exactly 1 cycle.
//  - push&pop, count>0: replace; entry[tos]=push_addr, tos and count
//    unchanged.
//  - push&pop, count==0: treated as push (count=1); underflow<=1.
//  - underflow is recomputed every edge: 0 unless set by the rules above.
//  - overflow holds until flush or rst.
//  - Wrap-around: tos arithmetic is modulo DEPTH only. After DEPTH+k pushes,
//    DEPTH pops return the last DEPTH addresses in LIFO order, then underflow.
//  - rst asserted mid-operation clears state regardless of inputs;
//    deassertion takes effect at the next edge.
// TESTING (DEPTH=4, AW=32)
//  - rst, then push 0x100,0x104,0x108 -> count=3, top_addr=0x108; three pops
//    -> 0x104, 0x100, then top_val=0, top_addr=0.
//  - Push 0x10,0x20,0x30,0x40,0x50 -> count=4, overflow=1, top=0x50; pops
//    give 0x40,0x30,0x20, then count=0 (0x10 lost).
//  - Pop while empty -> underflow=1 for one cycle, count=0; push&pop while
//    empty with 0x200 -> count=1, top=0x200, underflow pulse.
//  - Push 0x300,0x304, then push&pop 0x3FC -> count=2, top=0x3FC; pop ->
//    top=0x300.
//  - Push 0xA0,0xB0, flush with push_val=1 -> count=0, overflow=0,
//    top_val=0; next push 0xC0 -> top=0xC0, count=1.
//  - Assert rst asynchronously between edges with count=3 -> count, top_val
//    and overflow drop to 0 before the next rising edge.

Source files
------------

// File: rtl/proc_ras.sv
// Return-address stack predicting jr targets beside the fetch stage.
// Circular storage: pushing into a full stack overwrites the oldest entry.
module proc_ras #(
    parameter  int DEPTH = 8,
    parameter  int AW    = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_val,
    input  logic [AW-1:0] push_addr,
    input  logic          pop_val,
    output logic          top_val,
    output logic [AW-1:0] top_addr,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] entry_q [DEPTH];
    logic [AW-1:0] entry_d [DEPTH];
    logic [PW-1:0] tos_q, tos_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          empty;

    assign empty = (count_q == '0);

    // Next-state: flush beats push&pop, which beats push, which beats pop.
    always_comb begin
        entry_d     = entry_q;
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = 1'b0;
        if (flush) begin
            tos_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (push_val && (!pop_val || empty)) begin
            // Plain push, or push&pop on an empty stack acting as a push.
            tos_d          = tos_q + PW'(1);
            entry_d[tos_d] = push_addr;
            if (count_q == FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
            underflow_d = pop_val;
        end else if (push_val && pop_val) begin
            // Call returning into another call: replace top in place.
            entry_d[tos_q] = push_addr;
        end else if (pop_val) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                tos_d   = tos_q - PW'(1);
                count_d = count_q - CW'(1);
            end
        end
    end

    // State register with asynchronous clear of every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Outputs derive only from registered state.
    always_comb begin
        top_val   = !empty;
        top_addr  = empty ? '0 : entry_q[tos_q];
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_proc_ras.sv
// Bench for proc_ras: directed scenarios plus random traffic checked
// against a queue-based stack model through a scoreboard.
module tb_proc_ras;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          push_val = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic          pop_val = 1'b0;
    logic          top_val;
    logic [AW-1:0] top_addr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    proc_ras #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_val(push_val), .push_addr(push_addr), .pop_val(pop_val),
        .top_val(top_val), .top_addr(top_addr), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          tv;
        logic [AW-1:0] ta;
        int            cnt;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] stk[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string name, input logic [AW-1:0] act,
                       input logic [AW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.tv  = (stk.size() != 0);
        e.ta  = (stk.size() != 0) ? stk[stk.size()-1] : '0;
        e.cnt = stk.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    // Abstract stack semantics: a bounded LIFO that drops its oldest item.
    task automatic model(input logic f, input logic pu, input logic po,
                         input logic [AW-1:0] a);
        m_unf = 1'b0;
        if (f) begin
            stk.delete();
            m_ovf = 1'b0;
        end else if (pu && po && stk.size() != 0) begin
            stk[stk.size()-1] = a;
        end else if (pu) begin
            m_unf = po;
            if (stk.size() == DEPTH) begin
                void'(stk.pop_front());
                m_ovf = 1'b1;
            end
            stk.push_back(a);
        end else if (po) begin
            if (stk.size() != 0) void'(stk.pop_back());
            else m_unf = 1'b1;
        end
    endtask

    task automatic cyc(input logic f, input logic pu, input logic po,
                       input logic [AW-1:0] a);
        flush = f;
        push_val = pu;
        pop_val = po;
        push_addr = a;
        @(posedge clk);
        model(f, pu, po, a);
        exp_q.push_back(snap());
        #1;
        flush = 1'b0;
        push_val = 1'b0;
        pop_val = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a);
        cyc(1'b0, 1'b1, 1'b0, a);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, 1'b1, '0);
    endtask

    // Monitor: compare DUT outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("top_val", AW'(top_val), AW'(e.tv));
                chk("top_addr", top_addr, e.ta);
                chk("count", AW'(count), AW'(e.cnt));
                chk("overflow", AW'(overflow), AW'(e.ovf));
                chk("underflow", AW'(underflow), AW'(e.unf));
            end
        end
    end

    initial begin
        int r;
        int waited;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", AW'(count), '0);
        chk("rst_top_val", AW'(top_val), '0);
        chk("rst_top_addr", top_addr, '0);
        chk("rst_ovf", AW'(overflow), '0);
        chk("rst_unf", AW'(underflow), '0);
        @(posedge clk);
        #1 rst = 1'b0;

        push(32'h100); push(32'h104); push(32'h108);
        pop(); pop(); pop();

        push(32'h10); push(32'h20); push(32'h30);
        push(32'h40); push(32'h50);
        pop(); pop(); pop(); pop();

        pop();
        cyc(1'b0, 1'b1, 1'b1, 32'h200);
        pop();

        push(32'h300); push(32'h304);
        cyc(1'b0, 1'b1, 1'b1, 32'h3FC);
        pop(); pop();

        push(32'hA0); push(32'hB0);
        cyc(1'b1, 1'b1, 1'b0, 32'hEE);
        push(32'hC0);
        pop();

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            cyc(r < 4, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom & 32'hFFFC);
        end

        push(32'h1); push(32'h2); push(32'h3);
        push(32'h4); push(32'h5); pop();
        @(negedge clk);
        #1 rst = 1'b1;
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        chk("arst_count", AW'(count), '0);
        chk("arst_top_val", AW'(top_val), '0);
        chk("arst_top_addr", top_addr, '0);
        chk("arst_ovf", AW'(overflow), '0);
        #1 rst = 1'b0;
        push(32'hD0);
        pop();

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
